debug_print_sequencer: RTL and testbench

Sequences the debugger's dump printers (register, memory, pipeline-latch, ...) so they can share one UART transmitter. On a start request it launches each enabled printer in index order and waits for each to finish before launching the next. While a printer is active, the block routes that printer's write request and data to the UART and returns the UART's write-done to it. It sits between the debugger control FSM and the UART TX path. It is the only driver of the transmitter during a dump.

---
 rtl/debug_print_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_debug_print_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_print_sequencer.sv
// debug_print_sequencer
//   Shares one UART transmitter between the debugger's dump printers. On a
//   start request, each enabled printer is launched in index order, and the
//   block waits for each one to finish before it moves to the next. While a
//   printer runs, its write request and frame go straight to the UART
//   through a combinational path, and the UART write-done goes back to it.
//
//   Optional feature: define DEBUG_PRINT_SEQUENCER_END_FRAME_EN to send one
//   END_FRAME terminator over the UART after the last printer.
//
// Ports
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_start               dump request (sampled in IDLE only)
//   i_enable_mask         per-printer enable, latched with i_start
//   o_printer_start       one-cycle launch pulse per printer
//   i_printer_end         per-printer end level
//   i_printer_start_wr    per-printer UART write request
//   i_printer_data_wr     printer frames, printer k at [k*W +: W]
//   o_printer_wr_end      UART write-done routed to the active printer
//   o_uart_start_wr       UART write request
//   o_uart_data_wr        UART frame
//   i_uart_wr_end         UART write complete
//   o_active              current printer index (NUM_PRINTERS = past the end)
//   o_busy, o_end         dump in progress / dump complete (level)

// One lane per printer. The lane forwards its printer's traffic only when
// its printer is selected and the sequencer is in RUN.
module debug_print_lane #(
    parameter int DATA_OUT_BUS_SIZE = 56
) (
    input  logic                         sel,
    input  logic                         printer_start_wr,
    input  logic [DATA_OUT_BUS_SIZE-1:0] printer_data_wr,
    input  logic                         uart_wr_end,
    output logic                         uart_start_wr,
    output logic [DATA_OUT_BUS_SIZE-1:0] uart_data_wr,
    output logic                         printer_wr_end
);
    assign uart_start_wr  = sel & printer_start_wr;
    assign uart_data_wr   = sel ? printer_data_wr : '0;
    assign printer_wr_end = sel & uart_wr_end;
endmodule

module debug_print_sequencer #(
    parameter int DATA_OUT_BUS_SIZE = 56,
    parameter int NUM_PRINTERS      = 3
`ifdef DEBUG_PRINT_SEQUENCER_END_FRAME_EN
    ,
    parameter logic [DATA_OUT_BUS_SIZE-1:0] END_FRAME =
        {8'hFF, {(DATA_OUT_BUS_SIZE-8){1'b0}}}
`endif
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic                                   i_start,
    input  logic [NUM_PRINTERS-1:0]                i_enable_mask,
    output logic [NUM_PRINTERS-1:0]                o_printer_start,
    input  logic [NUM_PRINTERS-1:0]                i_printer_end,
    input  logic [NUM_PRINTERS-1:0]                i_printer_start_wr,
    input  logic [NUM_PRINTERS*DATA_OUT_BUS_SIZE-1:0] i_printer_data_wr,
    output logic [NUM_PRINTERS-1:0]                o_printer_wr_end,
    output logic                                   o_uart_start_wr,
    output logic [DATA_OUT_BUS_SIZE-1:0]           o_uart_data_wr,
    input  logic                                   i_uart_wr_end,
    output logic [$clog2(NUM_PRINTERS):0]          o_active,
    output logic                                   o_busy,
    output logic                                   o_end
);
    // One extra bit so that NUM_PRINTERS itself (the "past the last
    // printer" value) fits in the index.
    localparam int IDX_W = $clog2(NUM_PRINTERS) + 1;
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_PRINTERS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ARM,
        S_RUN,
`ifdef DEBUG_PRINT_SEQUENCER_END_FRAME_EN
        S_FRAME,
        S_FRAME_WAIT,
`endif
        S_DONE
    } state_t;

    state_t                                       state;
    logic [IDX_W-1:0]                             idx;
    logic [NUM_PRINTERS-1:0]                      mask_q;
    logic [NUM_PRINTERS-1:0]                      sel_oh;
    logic [NUM_PRINTERS-1:0]                      run_sel;
    logic [NUM_PRINTERS-1:0]                      lane_start;
    logic [NUM_PRINTERS-1:0][DATA_OUT_BUS_SIZE-1:0] lane_data;
    logic                                         in_run;
    logic                                         cur_mask;
    logic                                         cur_end;

    assign in_run   = (state == S_RUN);
    assign o_active = idx;

    for (genvar k = 0; k < NUM_PRINTERS; k++) begin : g_lane
        // The decode is all zeros when idx == NUM_PRINTERS, so nothing is routed.
        assign sel_oh[k]  = (idx == IDX_W'(k));
        assign run_sel[k] = in_run & sel_oh[k];

        debug_print_lane #(
            .DATA_OUT_BUS_SIZE (DATA_OUT_BUS_SIZE)
        ) u_lane (
            .sel              (run_sel[k]),
            .printer_start_wr (i_printer_start_wr[k]),
            .printer_data_wr  (i_printer_data_wr[k*DATA_OUT_BUS_SIZE +: DATA_OUT_BUS_SIZE]),
            .uart_wr_end      (i_uart_wr_end),
            .uart_start_wr    (lane_start[k]),
            .uart_data_wr     (lane_data[k]),
            .printer_wr_end   (o_printer_wr_end[k])
        );
    end

    assign cur_mask = |(mask_q & sel_oh);
    assign cur_end  = |(i_printer_end & sel_oh);

    // The UART path is combinational, so the printer's handshake timing
    // reaches the UART unchanged. It is held at 0 outside RUN because every
    // lane is gated off.
    always_comb begin
        o_uart_start_wr = |lane_start;
        o_uart_data_wr  = '0;
        for (int k = 0; k < NUM_PRINTERS; k++)
            o_uart_data_wr = o_uart_data_wr | lane_data[k];
`ifdef DEBUG_PRINT_SEQUENCER_END_FRAME_EN
        if (state == S_FRAME) begin
            o_uart_start_wr = 1'b1;
            o_uart_data_wr  = END_FRAME;
        end else if (state == S_FRAME_WAIT) begin
            o_uart_start_wr = 1'b0;
            o_uart_data_wr  = END_FRAME;
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= S_IDLE;
            idx             <= '0;
            mask_q          <= '0;
            o_printer_start <= '0;
            o_busy          <= 1'b0;
            o_end           <= 1'b0;
        end else begin
            o_printer_start <= '0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        mask_q <= i_enable_mask;
                        idx    <= '0;
                        o_end  <= 1'b0;
                        o_busy <= 1'b1;
                        state  <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (idx == IDX_END) begin
`ifdef DEBUG_PRINT_SEQUENCER_END_FRAME_EN
                        state  <= S_FRAME;
`else
                        o_end  <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= S_DONE;
`endif
                    end else if (!cur_mask) begin
                        idx <= idx + IDX_W'(1);
                    end else begin
                        o_printer_start <= sel_oh;
                        state           <= S_ARM;
                    end
                end
                // ARM gives the printer one edge to drop its stale end level
                // before RUN starts looking at it.
                S_ARM: state <= S_RUN;
                S_RUN: begin
                    if (cur_end) begin
                        idx   <= idx + IDX_W'(1);
                        state <= S_SELECT;
                    end
                end
`ifdef DEBUG_PRINT_SEQUENCER_END_FRAME_EN
                S_FRAME: state <= S_FRAME_WAIT;
                S_FRAME_WAIT: begin
                    if (i_uart_wr_end) begin
                        o_end  <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= S_DONE;
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_print_sequencer.sv
module tb_debug_print_sequencer;
    localparam int W  = 56;
    localparam int NP = 3;
    localparam int AW = $clog2(NP) + 1;
    localparam int FR = 2;
    localparam logic [W-1:0] END_FRAME_EXP = {8'hFF, 48'h0};
`ifdef DEBUG_PRINT_SEQUENCER_END_FRAME_EN
    localparam int EF = 1;
`else
    localparam int EF = 0;
`endif

    logic             i_clk = 1'b0;
    logic             i_reset = 1'b1;
    logic             i_start = 1'b0;
    logic [NP-1:0]    i_enable_mask = '0;
    logic [NP-1:0]    o_printer_start;
    logic [NP-1:0]    o_printer_wr_end;
    logic [NP-1:0]    pr_end = '1;
    logic [NP-1:0]    pr_swr = '0;
    logic [NP-1:0][W-1:0] pr_data = '0;
    logic [NP*W-1:0]  i_printer_data_wr;
    logic             o_uart_start_wr;
    logic [W-1:0]     o_uart_data_wr;
    logic             i_uart_wr_end = 1'b0;
    logic [AW-1:0]    o_active;
    logic             o_busy;
    logic             o_end;

    assign i_printer_data_wr = pr_data;

    debug_print_sequencer #(.DATA_OUT_BUS_SIZE(W), .NUM_PRINTERS(NP)) dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_start            (i_start),
        .i_enable_mask      (i_enable_mask),
        .o_printer_start    (o_printer_start),
        .i_printer_end      (pr_end),
        .i_printer_start_wr (pr_swr),
        .i_printer_data_wr  (i_printer_data_wr),
        .o_printer_wr_end   (o_printer_wr_end),
        .o_uart_start_wr    (o_uart_start_wr),
        .o_uart_data_wr     (o_uart_data_wr),
        .i_uart_wr_end      (i_uart_wr_end),
        .o_active           (o_active),
        .o_busy             (o_busy),
        .o_end              (o_end)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dump_no = 0;

    // printer / UART models
    bit pr_run[NP];
    int pr_left[NP];
    int pr_fno[NP];
    int ucnt = 0;
    logic [NP-1:0] s_pstart = '0, s_pwrend = '0;
    logic s_ureq = 1'b0;

    // schedule model
    logic [NP-1:0] m_mask = '0;
    int  arm_p = -1, arm_i = 0, done_p = -1, frame_p = -1, cur_i = 0, acc_p = 0;
    bit  waiting = 0, fw_m = 0, idle_m = 1, busy_m = 0, end_m = 0;

    // observations
    logic [W-1:0] frames[$];
    int st_cnt[NP], we_cnt[NP], arm_seen[NP], end_rise[NP];
    int oend_rise = -1;
    logic [NP-1:0] prev_end = '1;
    logic prev_oend = 1'b0;

    function automatic logic [W-1:0] frame_val(input int k, input int f, input int d);
        return {8'(8'h10 + k), 16'(f), 32'(32'hC0DE_0000 + d)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Arm time of the next enabled printer at or after 'from', given that the
    // SELECT scan for 'from' happens in period sp; each skipped printer costs
    // one period.
    task automatic sched(input int from, input int sp);
        arm_p = -1;
        for (int j = from; j < NP; j++) begin
            if (m_mask[j]) begin
                arm_p = sp + (j - from) + 1;
                arm_i = j;
                return;
            end
        end
`ifdef DEBUG_PRINT_SEQUENCER_END_FRAME_EN
        frame_p = sp + (NP - from) + 1;
`else
        done_p  = sp + (NP - from) + 1;
`endif
    endtask

    // Printers and UART: inputs change 1 unit after the rising edge, using
    // DUT outputs sampled on the previous falling edge.
    always @(posedge i_clk) begin
        #1;
        if (i_reset) begin
            pr_end = '1; pr_swr = '0; pr_data = '0;
            i_uart_wr_end = 1'b0; ucnt = 0;
            for (int k = 0; k < NP; k++) begin
                pr_run[k] = 0; pr_left[k] = 0; pr_fno[k] = 0;
            end
        end else begin
            i_uart_wr_end = 1'b0;
            if (ucnt != 0) begin
                if (ucnt == 1) i_uart_wr_end = 1'b1;
                ucnt--;
            end
            if (s_ureq) ucnt = 4;
            for (int k = 0; k < NP; k++) begin
                pr_swr[k] = 1'b0;
                if (s_pstart[k]) begin
                    pr_end[k] = 1'b0; pr_run[k] = 1; pr_fno[k] = 0; pr_left[k] = FR - 1;
                    pr_swr[k] = 1'b1; pr_data[k] = frame_val(k, 0, dump_no);
                end else if (pr_run[k] && s_pwrend[k]) begin
                    if (pr_left[k] > 0) begin
                        pr_fno[k]++; pr_left[k]--;
                        pr_swr[k] = 1'b1; pr_data[k] = frame_val(k, pr_fno[k], dump_no);
                    end else begin
                        pr_end[k] = 1'b1; pr_run[k] = 0; pr_data[k] = '0;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, outputs against the schedule model.
    always @(negedge i_clk) begin
        logic [NP-1:0] exp_ps, exp_we;
        logic          exp_sw;
        logic [W-1:0]  exp_dw;
        cyc++;
        if (i_reset) begin
            arm_p = -1; done_p = -1; frame_p = -1; waiting = 0; fw_m = 0;
            idle_m = 1; busy_m = 0; end_m = 0;
            s_pstart = '0; s_pwrend = '0; s_ureq = 1'b0;
            prev_end = '1; prev_oend = 1'b0;
        end else begin
            exp_sw = 1'b0; exp_dw = '0; exp_we = '0;
            for (int k = 0; k < NP; k++) begin
                exp_ps[k] = (cyc == arm_p) && (k == arm_i);
                if (pr_run[k]) begin
                    exp_sw = pr_swr[k]; exp_dw = pr_data[k]; exp_we[k] = i_uart_wr_end;
                end
            end
`ifdef DEBUG_PRINT_SEQUENCER_END_FRAME_EN
            if (cyc == frame_p) begin exp_sw = 1'b1; exp_dw = END_FRAME_EXP; end
            else if (fw_m)      begin exp_sw = 1'b0; exp_dw = END_FRAME_EXP; end
`endif
            check("printer_start", o_printer_start, exp_ps);
            check("busy", o_busy, busy_m);
            check("end", o_end, end_m);
            check("uart_start_wr", o_uart_start_wr, exp_sw);
            check("uart_data_wr", o_uart_data_wr, exp_dw);
            check("printer_wr_end", o_printer_wr_end, exp_we);
            if (cyc == arm_p)  check("active_arm", o_active, arm_i);
            if (cyc == done_p) check("active_done", o_active, NP);

            for (int k = 0; k < NP; k++) begin
                if (o_printer_start[k]) begin st_cnt[k]++; arm_seen[k] = cyc; end
                if (o_printer_wr_end[k]) we_cnt[k]++;
                if (pr_end[k] && !prev_end[k]) end_rise[k] = cyc;
            end
            prev_end = pr_end;
            if (o_uart_start_wr) frames.push_back(o_uart_data_wr);
            if (o_end && !prev_oend) oend_rise = cyc;
            prev_oend = o_end;

            if (waiting && pr_end[cur_i]) begin
                waiting = 0;
                sched(cur_i + 1, cyc + 1);
            end
            if (cyc == arm_p) begin waiting = 1; cur_i = arm_i; end
            if (fw_m && i_uart_wr_end) begin fw_m = 0; done_p = cyc + 1; end
            if (cyc == frame_p) fw_m = 1;
            if (idle_m && i_start) begin
                idle_m = 0; acc_p = cyc; m_mask = i_enable_mask;
                busy_m = 1; end_m = 0;
                sched(0, cyc + 1);
            end
            if (cyc + 1 == done_p) begin busy_m = 0; end_m = 1; end
            if (cyc == done_p) idle_m = 1;

            s_pstart = o_printer_start; s_pwrend = o_printer_wr_end; s_ureq = o_uart_start_wr;
        end
    end

    task automatic clear_stats();
        frames.delete();
        for (int k = 0; k < NP; k++) begin
            st_cnt[k] = 0; we_cnt[k] = 0; arm_seen[k] = -1; end_rise[k] = -1;
        end
        oend_rise = -1;
    endtask

    task automatic start_dump(input logic [NP-1:0] m);
        clear_stats();
        dump_no++;
        @(posedge i_clk); #1;
        i_enable_mask = m; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_enable_mask = ~m;  // must not affect the running dump
    endtask

    task automatic wait_end();
        int t = 0;
        while (!o_end && t < 3000) begin @(negedge i_clk); t++; end
        check("dump_completes", o_end, 1'b1);
        repeat (3) @(posedge i_clk);
    endtask

    task automatic check_frames(input logic [NP-1:0] m);
        logic [W-1:0] exp_q[$];
        for (int k = 0; k < NP; k++)
            if (m[k]) for (int f = 0; f < FR; f++) exp_q.push_back(frame_val(k, f, dump_no));
        if (EF != 0) exp_q.push_back(END_FRAME_EXP);
        check("frame_count", frames.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < frames.size(); i++)
            check("frame_data", frames[i], exp_q[i]);
    endtask

    initial begin
        logic [7:0] ids_all[6];
        int t;
        ids_all = '{8'h10, 8'h10, 8'h11, 8'h11, 8'h12, 8'h12};
        clear_stats();

        repeat (2) @(posedge i_clk);
        #2;
        check("rst_printer_start", o_printer_start, 0);
        check("rst_printer_wr_end", o_printer_wr_end, 0);
        check("rst_uart_start_wr", o_uart_start_wr, 0);
        check("rst_uart_data_wr", o_uart_data_wr, 0);
        check("rst_active", o_active, 0);
        check("rst_busy", o_busy, 0);
        check("rst_end", o_end, 0);
        @(negedge i_clk); #2; i_reset = 1'b0;
        repeat (2) @(posedge i_clk);

        // all printers, two frames each
        start_dump(3'b111);
        wait_end();
        check_frames(3'b111);
        check("all_frame_count", frames.size(), 6 + EF);
        for (int i = 0; i < 6; i++)
            check("all_frame_id", (frames.size() > i) ? frames[i][W-1:W-8] : 8'h00, ids_all[i]);
        for (int k = 0; k < NP; k++) check("all_start_once", st_cnt[k], 1);
`ifndef DEBUG_PRINT_SEQUENCER_END_FRAME_EN
        check("end_after_last", oend_rise - end_rise[2], 2);
`endif

        // printer 1 disabled: one skip cycle between printer 0 end and printer 2 arm
        start_dump(3'b101);
        wait_end();
        check_frames(3'b101);
        check("skip_p1_start", st_cnt[1], 0);
        check("skip_p1_wr_end", we_cnt[1], 0);
        check("skip_gap", arm_seen[2] - end_rise[0], 3);

        // nothing enabled
        start_dump(3'b000);
        wait_end();
        check_frames(3'b000);
`ifndef DEBUG_PRINT_SEQUENCER_END_FRAME_EN
        check("empty_no_uart", frames.size(), 0);
        check("empty_end_cycle", oend_rise - acc_p, 5);
`endif

        // printers still hold end from the previous dump
        start_dump(3'b111);
        wait_end();
        check_frames(3'b111);
        for (int k = 0; k < NP; k++) check("rerun_start_once", st_cnt[k], 1);

        // reset in the middle of printer 1's frame
        start_dump(3'b111);
        t = 0;
        while (!pr_swr[1] && t < 3000) begin @(negedge i_clk); t++; end
        check("reached_p1_write", pr_swr[1], 1'b1);
        check("pre_reset_uart_start", o_uart_start_wr, 1'b1);
        #2; i_reset = 1'b1; #1;
        check("arst_uart_start_wr", o_uart_start_wr, 0);
        check("arst_uart_data_wr", o_uart_data_wr, 0);
        check("arst_printer_wr_end", o_printer_wr_end, 0);
        check("arst_printer_start", o_printer_start, 0);
        check("arst_active", o_active, 0);
        check("arst_busy", o_busy, 0);
        check("arst_end", o_end, 0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk); #2; i_reset = 1'b0;
        repeat (2) @(posedge i_clk);
        start_dump(3'b111);
        wait_end();
        check_frames(3'b111);
        check("restart_first_id", (frames.size() > 0) ? frames[0][W-1:W-8] : 8'h00, 8'h10);
        for (int k = 0; k < NP; k++) check("restart_start_once", st_cnt[k], 1);

`ifdef DEBUG_PRINT_SEQUENCER_END_FRAME_EN
        start_dump(3'b001);
        wait_end();
        check_frames(3'b001);
        check("term_count", frames.size(), 3);
        check("term_frame", (frames.size() > 2) ? frames[2] : '0, END_FRAME_EXP);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end
endmodule
